eth_tx_frame_arbiter: RTL and testbench

- Frame-level round-robin arbiter that shares the single 8-bit transmit AXI-stream input of the 1G RGMII MAC+FIFO among S_COUNT frame sources (e.g. OFDM payload packer, ARP/ICMP responder, control channel).
- Holds the grant for a whole frame; frames never interleave.
- Stall watchdog: a source that stalls mid-frame gets its frame terminated with tuser=1 so the MAC TX frame FIFO drops it. The rest of that source's frame is then drained and discarded.

---
 rtl/eth_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/eth_tx_frame_arbiter.sv | 166 ++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: default stream width
// and the state encoding of the transmit frame arbiter.
package eth_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The requester scanned first is the one
// after last_index, wrapping around, so the previous winner has the lowest
// priority. Reusable wherever a fair pick over N requesters is needed.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_index,
    output logic             gnt_valid,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_index
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;
    logic             found_s;
    logic [IDX_W-1:0] index_s;

    // Scan from last_index+1 upward with wrap; the first requester seen wins
    always_comb begin
        found_s = 1'b0;
        index_s = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s  = IDX_W'((int'(last_index) + k) % N);
            hit_s   = ~found_s & req[cand_s];
            index_s = hit_s ? cand_s : index_s;
            found_s = found_s | hit_s;
        end
    end

    assign gnt_valid  = found_s;
    assign gnt_index  = index_s;
    assign gnt_onehot = found_s ? ({{(N-1){1'b0}}, 1'b1} << index_s) : {N{1'b0}};

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter feeding the MAC transmit stream. A grant is
// held for a whole frame. A source that stalls mid-frame for TIMEOUT cycles
// has its frame closed with tuser=1 (so the MAC FIFO drops it), and the rest
// of that source's frame is then accepted and discarded.
module eth_tx_frame_arbiter
    import eth_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          grant_valid,
    output logic [$clog2(S_COUNT)-1:0]    grant_index,
    output logic [CNT_WIDTH-1:0]          frame_count,
    output logic [CNT_WIDTH-1:0]          abort_count
);

    localparam int IDX_W = $clog2(S_COUNT);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT > 0) ? TIMEOUT : 1);

    arb_state_t           state_r;
    logic [IDX_W-1:0]     grant_index_r;
    logic [S_COUNT-1:0]   grant_onehot_r;
    logic [IDX_W-1:0]     rr_r;
    logic [WD_W-1:0]      wd_cnt_r;
    logic [CNT_WIDTH-1:0] frame_count_r;
    logic [CNT_WIDTH-1:0] abort_count_r;

    logic [DATA_WIDTH-1:0] src_data_s [S_COUNT];
    logic                  arb_valid_s;
    logic [S_COUNT-1:0]    arb_onehot_s;
    logic [IDX_W-1:0]      arb_index_s;
    logic [DATA_WIDTH-1:0] g_data_s;
    logic                  g_valid_s;
    logic                  g_last_s;
    logic                  g_user_s;
    logic                  src_hs_s;
    logic [WD_W-1:0]       wd_next_s;

    for (genvar i = 0; i < S_COUNT; i++) begin : g_src
        assign src_data_s[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N     (S_COUNT),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (s_axis_tvalid),
        .last_index (rr_r),
        .gnt_valid  (arb_valid_s),
        .gnt_onehot (arb_onehot_s),
        .gnt_index  (arb_index_s)
    );

    assign g_data_s  = src_data_s[grant_index_r];
    assign g_valid_s = s_axis_tvalid[grant_index_r];
    assign g_last_s  = s_axis_tlast[grant_index_r];
    assign g_user_s  = s_axis_tuser[grant_index_r];
    assign src_hs_s  = g_valid_s & m_axis_tready;
    assign wd_next_s = wd_cnt_r + WD_W'(1);

    assign grant_valid = (state_r != IDLE);
    assign grant_index = grant_index_r;
    assign frame_count = frame_count_r;
    assign abort_count = abort_count_r;

    // Stream routing: pass-through while active, forced bad tail on abort, sink while draining
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (state_r)
            ACTIVE: begin
                m_axis_tdata  = g_data_s;
                m_axis_tvalid = g_valid_s;
                m_axis_tlast  = g_last_s;
                m_axis_tuser  = g_user_s;
                s_axis_tready = grant_onehot_r & {S_COUNT{m_axis_tready}};
            end
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            DRAIN: begin
                s_axis_tready = grant_onehot_r;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    // Frame FSM with grant register, rotation pointer, stall watchdog and status counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            grant_index_r  <= '0;
            grant_onehot_r <= '0;
            rr_r           <= IDX_W'(S_COUNT - 1);
            wd_cnt_r       <= '0;
            frame_count_r  <= '0;
            abort_count_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    wd_cnt_r <= '0;
                    if (arb_valid_s) begin
                        grant_index_r  <= arb_index_s;
                        grant_onehot_r <= arb_onehot_s;
                        rr_r           <= arb_index_s;
                        state_r        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (src_hs_s) begin
                        wd_cnt_r <= '0;
                        if (g_last_s) begin
                            frame_count_r <= frame_count_r + CNT_WIDTH'(1);
                            state_r       <= IDLE;
                        end
                    end else if ((TIMEOUT > 0) && !g_valid_s) begin
                        // Backpressure with valid data never reaches this branch
                        wd_cnt_r <= wd_next_s;
                        if (wd_next_s == WD_LIMIT) begin
                            state_r <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    if (m_axis_tready) begin
                        if (abort_count_r != {CNT_WIDTH{1'b1}}) begin
                            abort_count_r <= abort_count_r + CNT_WIDTH'(1);
                        end
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (g_valid_s && g_last_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: per-source beat queues feed the
// inputs, accepted output beats are captured and compared with hand-computed
// frames.
module tb_eth_tx_frame_arbiter;

    localparam int S  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic [1:0] gidx;
    } mbeat_t;

    logic            clk;
    logic            rst_n;
    logic [S*DW-1:0] s_axis_tdata;
    logic [S-1:0]    s_axis_tvalid;
    logic [S-1:0]    s_axis_tready;
    logic [S-1:0]    s_axis_tlast;
    logic [S-1:0]    s_axis_tuser;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic            grant_valid;
    logic [1:0]      grant_index;
    logic [15:0]     frame_count;
    logic [15:0]     abort_count;

    beat_t  srcq [S][$];
    mbeat_t cap [$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     acc [S];
    int     hs0_cyc   = 0;
    int     abort_cyc = 0;
    logic   bp_toggle = 1'b0;

    eth_tx_frame_arbiter #(
        .S_COUNT    (S),
        .DATA_WIDTH (DW),
        .TIMEOUT    (16),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index),
        .frame_count   (frame_count),
        .abort_count   (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mbeat_t exp_beat(input logic [7:0] d, input logic l, input logic u, input logic [1:0] g);
        mbeat_t e;
        e.data = d;
        e.last = l;
        e.user = u;
        e.gidx = g;
        return e;
    endfunction

    task automatic check_cap(input string tag, input int idx, input mbeat_t e);
        if (idx < cap.size()) begin
            check_val($sformatf("%s_beat%0d", tag, idx), 32'(cap[idx]), 32'(e));
        end else begin
            check_val($sformatf("%s_missing%0d", tag, idx), 32'(cap.size()), 32'(idx + 1));
        end
    endtask

    function automatic logic q_empty();
        logic e;
        e = 1'b1;
        for (int i = 0; i < S; i++) begin
            if (srcq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < S; i++) begin
            if (srcq[i].size() > 0) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tdata[i*DW +: DW]  = srcq[i][0].data;
                s_axis_tlast[i]           = srcq[i][0].last;
                s_axis_tuser[i]           = srcq[i][0].user;
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tdata[i*DW +: DW]  = 8'h00;
                s_axis_tlast[i]           = 1'b0;
                s_axis_tuser[i]           = 1'b0;
            end
        end
    endtask

    task automatic load_frame(input int src, input int n, input int base, input logic with_last, input logic bad_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = 8'(base + i);
            b.last = with_last && (i == n - 1);
            b.user = bad_last && (i == n - 1);
            srcq[src].push_back(b);
        end
        drive_src();
    endtask

    // One clock: sample handshakes on the falling edge, update sources after the rising edge
    task automatic step();
        logic [S-1:0] hs;
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        if (hs[0]) hs0_cyc = cyc;
        if (m_axis_tvalid && m_axis_tready) begin
            cap.push_back(exp_beat(m_axis_tdata, m_axis_tlast, m_axis_tuser, grant_index));
            if (m_axis_tuser) abort_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < S; i++) begin
            if (hs[i] && srcq[i].size() > 0) begin
                srcq[i].delete(0);
                acc[i]++;
            end
        end
        if (bp_toggle) m_axis_tready = ~m_axis_tready;
        drive_src();
    endtask

    task automatic run_until_idle(input string tag, input int max_cyc);
        logic done;
        done = 1'b0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            step();
            done = q_empty() && (grant_valid == 1'b0);
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int order [3];
        int fc_before;
        logic seen;
        order = '{0, 1, 3};
        for (int i = 0; i < S; i++) acc[i] = 0;

        // Reset with sources and sink active: nothing may be driven
        rst_n         = 1'b0;
        s_axis_tdata  = {S*DW{1'b1}};
        s_axis_tvalid = {S{1'b1}};
        s_axis_tlast  = {S{1'b0}};
        s_axis_tuser  = {S{1'b0}};
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("rst_mdata", 32'(m_axis_tdata), 32'd0);
        check_val("rst_mlast_user", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
        check_val("rst_sready", 32'(s_axis_tready), 32'd0);
        check_val("rst_gvalid", 32'(grant_valid), 32'd0);
        check_val("rst_gindex", 32'(grant_index), 32'd0);
        check_val("rst_fcount", 32'(frame_count), 32'd0);
        check_val("rst_acount", 32'(abort_count), 32'd0);
        drive_src();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single 60-byte frame from source 2
        cap.delete();
        load_frame(2, 60, 0, 1'b1, 1'b0);
        run_until_idle("single", 200);
        check_val("single_nbeats", 32'(cap.size()), 32'd60);
        for (int i = 0; i < 60; i++) check_cap("single", i, exp_beat(8'(i), i == 59, 1'b0, 2'd2));
        check_val("single_fcount", 32'(frame_count), 32'd1);

        // Reset in the middle of a frame from source 2
        cap.delete();
        acc[2] = 0;
        load_frame(2, 60, 0, 1'b1, 1'b0);
        for (int n = 0; n < 100 && acc[2] < 30; n++) step();
        check_val("midrst_progress", 32'(acc[2]), 32'd30);
        rst_n = 1'b0;
        #1;
        check_val("midrst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("midrst_sready", 32'(s_axis_tready), 32'd0);
        check_val("midrst_gvalid", 32'(grant_valid), 32'd0);
        check_val("midrst_fcount", 32'(frame_count), 32'd0);
        check_val("midrst_acount", 32'(abort_count), 32'd0);
        for (int i = 0; i < S; i++) srcq[i].delete();
        drive_src();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cap.delete();

        // Contention: sources 0,1,3 with two 10-byte frames each; source 0 first after reset
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 3; k++) load_frame(order[k], 10, order[k] * 64 + f * 16, 1'b1, 1'b0);
        end
        run_until_idle("cont", 300);
        check_val("cont_nbeats", 32'(cap.size()), 32'd60);
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < 10; b++) begin
                check_cap("cont", k * 10 + b,
                          exp_beat(8'(order[k % 3] * 64 + (k / 3) * 16 + b), b == 9, 1'b0, 2'(order[k % 3])));
            end
        end
        check_val("cont_fcount", 32'(frame_count), 32'd6);

        // Backpressure toggling during a 64-byte frame from source 1
        cap.delete();
        bp_toggle = 1'b1;
        load_frame(1, 64, 0, 1'b1, 1'b0);
        run_until_idle("bp", 400);
        bp_toggle     = 1'b0;
        m_axis_tready = 1'b1;
        check_val("bp_nbeats", 32'(cap.size()), 32'd64);
        for (int i = 0; i < 64; i++) check_cap("bp", i, exp_beat(8'(i), i == 63, 1'b0, 2'd1));
        check_val("bp_acount", 32'(abort_count), 32'd0);
        check_val("bp_fcount", 32'(frame_count), 32'd7);

        // Watchdog: source 0 sends 5 bytes then stalls until the abort beat appears
        cap.delete();
        fc_before = int'(frame_count);
        seen = 1'b0;
        load_frame(0, 5, 8'hA0, 1'b0, 1'b0);
        for (int n = 0; n < 80 && !seen; n++) begin
            step();
            seen = (cap.size() > 0) && cap[cap.size() - 1].user;
        end
        check_val("wd_abort_seen", 32'(seen), 32'd1);
        check_val("wd_stall_gap", 32'(abort_cyc - hs0_cyc), 32'd17);
        load_frame(0, 20, 8'h40, 1'b1, 1'b0);
        run_until_idle("wd", 100);
        check_val("wd_nbeats", 32'(cap.size()), 32'd6);
        for (int i = 0; i < 5; i++) check_cap("wd", i, exp_beat(8'(8'hA0 + i), 1'b0, 1'b0, 2'd0));
        check_cap("wd", 5, exp_beat(8'h00, 1'b1, 1'b1, 2'd0));
        check_val("wd_acount", 32'(abort_count), 32'd1);
        check_val("wd_fcount", 32'(frame_count), 32'(fc_before));

        // Source-marked bad frame from source 3 passes through and counts as a frame
        cap.delete();
        load_frame(3, 20, 8'h80, 1'b1, 1'b1);
        run_until_idle("badf", 100);
        check_val("badf_nbeats", 32'(cap.size()), 32'd20);
        for (int i = 0; i < 20; i++) check_cap("badf", i, exp_beat(8'(8'h80 + i), i == 19, i == 19, 2'd3));
        check_val("badf_fcount", 32'(frame_count), 32'(fc_before + 1));
        check_val("badf_acount", 32'(abort_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
